// File: rtl/sync_up_counter_mod.sv
// -----------------------------------------------------------------------------
// sync_up_counter_mod
//   Synchronous modulo-(MAX_VAL+1) up counter with enable, synchronous clear,
//   saturating parallel load and a start/stop control FSM (IDLE/RUN/DONE).
//   With ONE_SHOT=1 the counter stops at MAX_VAL and raises done until the
//   next start. carry_out_o feeds en_i of the next stage so instances can be
//   chained into wider counters.
//
// Parameters
//   WIDTH     counter width in bits
//   MAX_VAL   terminal value (counts 0..MAX_VAL), must be < 2**WIDTH
//   ONE_SHOT  0 = wrap MAX_VAL->0 forever, 1 = stop at MAX_VAL and enter DONE
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   en_i         count enable (only advances in RUN)
//   clr_i        synchronous clear (count=0, IDLE, done=0)
//   load_i       synchronous parallel load (saturated to MAX_VAL)
//   load_val_i   value for load_i
//   start_i      IDLE->RUN, or DONE->RUN with count restarted at 0
//   stop_i       RUN->IDLE, count held
//   count_o      current count (registered)
//   tc_o         count_o == MAX_VAL
//   carry_out_o  tc_o & en_i & RUN, for cascading
//   done_o       registered, high while in DONE
// -----------------------------------------------------------------------------
module sync_up_counter_mod #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 15,
  parameter int ONE_SHOT = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             carry_out_o,
  output logic             done_o
);

  // Reject a terminal value that does not fit in the counter.
  generate
    if ((MAX_VAL < 0) || (MAX_VAL >= (1 << WIDTH))) begin : g_bad_max_val
      $error("sync_up_counter_mod: MAX_VAL must be in 0 .. 2**WIDTH-1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_C = '0;
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;

  // Load values above the terminal value are clamped so the count never
  // leaves the 0..MAX_VAL range.
  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
    if (v > MAX_C) begin
      return MAX_C;
    end else begin
      return v;
    end
  endfunction

  // State, count and done registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      count_q <= ZERO_C;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. Priority: clr > load > start/stop > counting.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = done_q;
    if (clr_i) begin
      state_d = ST_IDLE;
      count_d = ZERO_C;
      done_d  = 1'b0;
    end else if (load_i) begin
      // Load replaces the count step for this edge; the FSM stays put.
      count_d = sat_load(load_val_i);
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Start only arms the counter; first increment comes on a later edge.
          if (start_i) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          // stop beats start and beats counting on the same edge.
          if (stop_i) begin
            state_d = ST_IDLE;
          end else if (en_i) begin
            if (count_q < MAX_C) begin
              count_d = count_q + ONE_C;
            end else if (ONE_SHOT != 0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              count_d = ZERO_C;
            end
          end else begin
            count_d = count_q;
          end
        end
        ST_DONE: begin
          if (start_i) begin
            state_d = ST_RUN;
            count_d = ZERO_C;
            done_d  = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = ZERO_C;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign count_o     = count_q;
  assign done_o      = done_q;
  assign tc_o        = (count_q == MAX_C);
  assign carry_out_o = tc_o & en_i & (state_q == ST_RUN);

endmodule

// File: tb/tb_sync_up_counter_mod.sv
// -----------------------------------------------------------------------------
// tb_sync_up_counter_mod
//   Directed bench for sync_up_counter_mod. Three instances:
//     u0: WIDTH=4, MAX_VAL=15, ONE_SHOT=0
//     u1: WIDTH=4, MAX_VAL=9,  ONE_SHOT=0
//     u2: WIDTH=4, MAX_VAL=5,  ONE_SHOT=1
//   Each instance has its own control inputs; clock and reset are shared.
// -----------------------------------------------------------------------------
module tb_sync_up_counter_mod;

  logic       clk_s;
  logic       rst_ns;
  logic [2:0] en_s, clr_s, load_s, start_s, stop_s;
  logic [3:0] lv0_s, lv1_s, lv2_s;
  logic [3:0] cnt0_s, cnt1_s, cnt2_s;
  logic [2:0] tc_s, co_s, done_s;

  int n_cmp_r;
  int n_bad_r;

  sync_up_counter_mod #(.WIDTH(4), .MAX_VAL(15), .ONE_SHOT(0)) u0 (
    .clk_i(clk_s), .rst_ni(rst_ns), .en_i(en_s[0]), .clr_i(clr_s[0]),
    .load_i(load_s[0]), .load_val_i(lv0_s), .start_i(start_s[0]),
    .stop_i(stop_s[0]), .count_o(cnt0_s), .tc_o(tc_s[0]),
    .carry_out_o(co_s[0]), .done_o(done_s[0])
  );

  sync_up_counter_mod #(.WIDTH(4), .MAX_VAL(9), .ONE_SHOT(0)) u1 (
    .clk_i(clk_s), .rst_ni(rst_ns), .en_i(en_s[1]), .clr_i(clr_s[1]),
    .load_i(load_s[1]), .load_val_i(lv1_s), .start_i(start_s[1]),
    .stop_i(stop_s[1]), .count_o(cnt1_s), .tc_o(tc_s[1]),
    .carry_out_o(co_s[1]), .done_o(done_s[1])
  );

  sync_up_counter_mod #(.WIDTH(4), .MAX_VAL(5), .ONE_SHOT(1)) u2 (
    .clk_i(clk_s), .rst_ni(rst_ns), .en_i(en_s[2]), .clr_i(clr_s[2]),
    .load_i(load_s[2]), .load_val_i(lv2_s), .start_i(start_s[2]),
    .stop_i(stop_s[2]), .count_o(cnt2_s), .tc_o(tc_s[2]),
    .carry_out_o(co_s[2]), .done_o(done_s[2])
  );

  // 10 ns clock.
  initial begin
    clk_s = 1'b0;
    forever #5 clk_s = ~clk_s;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp_r++;
    if (obs != exp) begin
      n_bad_r++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle 1 ns after it.
  task automatic step();
    @(posedge clk_s);
    #1;
  endtask

  task automatic pulse_start(input int k);
    start_s[k] = 1'b1;
    step();
    start_s[k] = 1'b0;
  endtask

  initial begin
    n_cmp_r = 0;
    n_bad_r = 0;
    en_s = 3'b000; clr_s = 3'b000; load_s = 3'b000;
    start_s = 3'b000; stop_s = 3'b000;
    lv0_s = 4'd0; lv1_s = 4'd0; lv2_s = 4'd0;
    rst_ns = 1'b0;
    #12;
    chk("rst_count", int'(cnt0_s), 0);
    chk("rst_tc", int'(tc_s[0]), 0);
    chk("rst_carry", int'(co_s[0]), 0);
    chk("rst_done", int'(done_s[2]), 0);
    rst_ns = 1'b1;
    step();

    // ---- Test 1: async reset mid-count ----
    pulse_start(0);
    en_s[0] = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("t1_count7", int'(cnt0_s), 7);
    #2 rst_ns = 1'b0;
    #1;
    chk("t1_async_count", int'(cnt0_s), 0);
    chk("t1_async_tc", int'(tc_s[0]), 0);
    chk("t1_async_carry", int'(co_s[0]), 0);
    rst_ns = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("t1_hold_idle", int'(cnt0_s), 0);

    // ---- Test 2: 17 edges through the wrap ----
    en_s[0] = 1'b0;
    pulse_start(0);
    chk("t2_start_nostep", int'(cnt0_s), 0);
    en_s[0] = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      chk($sformatf("t2_count_%0d", i), int'(cnt0_s), i % 16);
      chk($sformatf("t2_carry_%0d", i), int'(co_s[0]), ((i % 16) == 15) ? 1 : 0);
    end

    // ---- Test 6: hold at 15 with en=0, then stop at 4 ----
    for (int i = 0; i < 14; i++) step();
    chk("t6_at15", int'(cnt0_s), 15);
    en_s[0] = 1'b0;
    #1;
    chk("t6_tc", int'(tc_s[0]), 1);
    chk("t6_carry_en0", int'(co_s[0]), 0);
    step();
    chk("t6_hold15", int'(cnt0_s), 15);
    en_s[0] = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t6_at4", int'(cnt0_s), 4);
    stop_s[0] = 1'b1;
    start_s[0] = 1'b1;
    step();
    stop_s[0] = 1'b0;
    start_s[0] = 1'b0;
    chk("t6_stop_nostep", int'(cnt0_s), 4);
    step();
    step();
    chk("t6_idle_hold", int'(cnt0_s), 4);

    // ---- Test 5: clr beats load and stop; load alone keeps state ----
    pulse_start(0);
    for (int i = 0; i < 4; i++) step();
    chk("t5_at8", int'(cnt0_s), 8);
    clr_s[0] = 1'b1; load_s[0] = 1'b1; lv0_s = 4'd3; stop_s[0] = 1'b1;
    step();
    clr_s[0] = 1'b0; load_s[0] = 1'b0; stop_s[0] = 1'b0;
    chk("t5_clr", int'(cnt0_s), 0);
    step();
    chk("t5_idle_after_clr", int'(cnt0_s), 0);
    load_s[0] = 1'b1;
    step();
    load_s[0] = 1'b0;
    chk("t5_load3", int'(cnt0_s), 3);
    step();
    chk("t5_still_idle", int'(cnt0_s), 3);
    en_s[0] = 1'b0;

    // ---- Test 3: MAX_VAL=9 wrap and saturated load ----
    pulse_start(1);
    chk("t3_tc_at0", int'(tc_s[1]), 0);
    en_s[1] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("t3_count_%0d", i), int'(cnt1_s), i % 10);
      chk($sformatf("t3_tc_%0d", i), int'(tc_s[1]), ((i % 10) == 9) ? 1 : 0);
    end
    lv1_s = 4'd12;
    load_s[1] = 1'b1;
    step();
    load_s[1] = 1'b0;
    chk("t3_load_sat", int'(cnt1_s), 9);
    chk("t3_load_tc", int'(tc_s[1]), 1);
    step();
    chk("t3_wrap_after_load", int'(cnt1_s), 0);
    en_s[1] = 1'b0;

    // ---- Test 4: ONE_SHOT with MAX_VAL=5 ----
    pulse_start(2);
    en_s[2] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("t4_count_%0d", i), int'(cnt2_s), i);
      chk($sformatf("t4_done_%0d", i), int'(done_s[2]), 0);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("t4_hold_%0d", i), int'(cnt2_s), 5);
      chk($sformatf("t4_doneh_%0d", i), int'(done_s[2]), 1);
    end
    chk("t4_carry_done", int'(co_s[2]), 0);
    pulse_start(2);
    chk("t4_restart_count", int'(cnt2_s), 0);
    chk("t4_restart_done", int'(done_s[2]), 0);
    step();
    chk("t4_resume", int'(cnt2_s), 1);
    step();
    chk("t4_resume2", int'(cnt2_s), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp_r, n_bad_r);
    $finish;
  end

endmodule
